// File: rtl/bht_ctrl_if.sv
// rtl/bht_ctrl_if.sv - lookup/resolve/status bundle between fetch and the branch history table
interface bht_ctrl_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          lookup_vld;
  logic [15:0]   lookup_pc;
  logic          lookup_rdy;
  logic          pred_take;
  logic          resolve_vld;
  logic          resolve_taken;
  logic          flush;
  logic          mispredict;
  logic          resolve_err;
  logic          init_busy;
  logic [CW-1:0] inflight_cnt;

  modport master (
    output lookup_vld, lookup_pc, resolve_vld, resolve_taken, flush,
    input  lookup_rdy, pred_take, mispredict, resolve_err, init_busy, inflight_cnt
  );

  modport slave (
    input  lookup_vld, lookup_pc, resolve_vld, resolve_taken, flush,
    output lookup_rdy, pred_take, mispredict, resolve_err, init_busy, inflight_cnt
  );
endinterface

// File: rtl/bht_ctrl.sv
// rtl/bht_ctrl.sv - 2-bit saturating-counter branch predictor with in-order in-flight FIFO
module bht_ctrl #(
  parameter int IDX_W = 4,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  bht_ctrl_if.slave   bus
);
  localparam int N  = 1 << IDX_W;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {INIT, RUN} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] init_idx;
  logic [1:0]       ctr [N];
  logic [IDX_W-1:0] fifo_idx [DEPTH];
  logic             fifo_pred [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [1:0]       upd_old, upd_new;
  logic             busy, rdy, run_ok, push, pop, bad_resolve, pred;

  assign lk_idx  = bus.lookup_pc[IDX_W+1:2];
  assign pred    = ctr[lk_idx][1];
  assign upd_idx = fifo_idx[rd_ptr];
  assign upd_old = ctr[upd_idx];

  always_comb begin
    upd_new = upd_old;
    if (bus.resolve_taken) begin
      if (upd_old != 2'b11) upd_new = upd_old + 2'b01;
    end else begin
      if (upd_old != 2'b00) upd_new = upd_old - 2'b01;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    rdy       = 1'b0;
    case (state)
      INIT: begin
        busy = 1'b1;
        if (init_idx == '1) state_nxt = RUN;
      end
      RUN: rdy = (cnt < CW'(DEPTH)) && !bus.flush;
      default: state_nxt = INIT;
    endcase
  end

  // Flush outranks both lookup and resolve in the same cycle.
  assign run_ok      = (state == RUN) && !bus.flush;
  assign push        = bus.lookup_vld && rdy;
  assign pop         = run_ok && bus.resolve_vld && (cnt != '0);
  assign bad_resolve = run_ok && bus.resolve_vld && (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst)       init_idx <= '0;
    else if (busy) init_idx <= init_idx + IDX_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (busy)     ctr[init_idx] <= 2'b11;
      else if (pop) ctr[upd_idx]  <= upd_new;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx[wr_ptr]  <= lk_idx;
      fifo_pred[wr_ptr] <= pred;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (state == RUN && bus.flush)) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mispredict  <= 1'b0;
      bus.resolve_err <= 1'b0;
    end else begin
      bus.mispredict  <= pop && (bus.resolve_taken != fifo_pred[rd_ptr]);
      bus.resolve_err <= bad_resolve;
    end
  end

  assign bus.pred_take    = pred;
  assign bus.lookup_rdy   = rdy;
  assign bus.init_busy    = busy;
  assign bus.inflight_cnt = cnt;
endmodule

// File: doc/bht_ctrl.md
BHT_CTRL -- requirements
Module: bht_ctrl

Interface
REQ-001 SHALL have parameter IDX_W, default 4, meaning table index width (2^IDX_W two-bit counters).
REQ-002 SHALL have parameter DEPTH, default 4, meaning maximum in-flight (predicted, unresolved) branches; power of two.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port lookup_vld  input  1  fetch requests a prediction this cycle.
REQ-006 SHALL have port lookup_pc  input  16  branch PC; table index = lookup_pc[IDX_W+1:2].
REQ-007 SHALL have port lookup_rdy  output  1  block accepts a lookup this cycle.
REQ-008 SHALL have port pred_take  output  1  prediction for the current lookup, combinational, valid when lookup_vld && lookup_rdy.
REQ-009 SHALL have port resolve_vld  input  1  oldest in-flight branch resolved this cycle.
REQ-010 SHALL have port resolve_taken  input  1  actual outcome of that branch.
REQ-011 SHALL have port flush  input  1  discard all in-flight entries.
REQ-012 SHALL have port mispredict  output  1  registered one-cycle pulse: last accepted resolve disagreed with its prediction.
REQ-013 SHALL have port resolve_err  output  1  registered one-cycle pulse: resolve_vld with no in-flight entry.
REQ-014 SHALL have port init_busy  output  1  table initialization sweep in progress.
REQ-015 SHALL have port inflight_cnt  output  $clog2(DEPTH)+1  current in-flight entry count.

Function
REQ-016 SHALL hold 2^IDX_W saturating 2-bit counters: 00 strongly not taken, 01 not taken, 10 taken, 11 strongly taken; prediction = counter[1].
REQ-017 SHALL update on resolve: taken increments, saturating at 11; not taken decrements, saturating at 00.
REQ-018 SHALL implement FSM states INIT and RUN; INIT writes 2'b11 to one entry per cycle, index 0 upward, then enters RUN the cycle after writing entry 2^IDX_W-1 (2^IDX_W cycles in INIT).
REQ-019 SHALL drive init_busy=1 and lookup_rdy=0 in INIT; resolve_vld and flush in INIT are ignored (no error pulse).
REQ-020 SHALL in RUN drive lookup_rdy=1 iff inflight_cnt < DEPTH; a simultaneous resolve does not raise lookup_rdy in the same cycle.
REQ-021 SHALL on an accepted lookup push {index, pred_take} into an in-order in-flight FIFO; pointers wrap modulo DEPTH.
REQ-022 SHALL on resolve_vld with inflight_cnt>0 pop the oldest entry, update its counter and set mispredict next cycle iff resolve_taken != stored prediction.
REQ-023 SHALL on resolve_vld with inflight_cnt=0 leave the table unchanged and pulse resolve_err next cycle.
REQ-024 SHALL on same-cycle lookup and resolve to the same index give pred_take from the pre-update counter; both push and pop occur, inflight_cnt unchanged.
REQ-025 SHALL on flush in RUN empty the FIFO next cycle (inflight_cnt=0); flush has priority: same-cycle lookup is not accepted (lookup_rdy=0 while flush=1) and same-cycle resolve neither updates nor flags.
REQ-026 SHALL never modify counters on flush.

Reset
REQ-027 SHALL on rst=1 at a rising edge enter INIT at index 0, clear FIFO pointers and inflight_cnt, and clear mispredict and resolve_err, regardless of current state (including mid-INIT).
REQ-028 SHALL drive pred_take equal to bit 1 of the addressed counter at all times; after INIT completes all entries read 11 (pred_take=1).

Verification
REQ-029 SHALL cover: rst for 1 cycle, IDX_W=4 -> init_busy=1, lookup_rdy=0 for exactly 16 cycles, then lookup of pc 0x0040 gives pred_take=1.
REQ-030 SHALL cover: pc 0x0010 (index 4) looked up and resolved not-taken 3 times -> predictions 1,1,0; mispredict pulses 1,1,0; counter ends 00; one taken resolve -> 01, next prediction 0.
REQ-031 SHALL cover: 4 lookups without resolve -> inflight_cnt=4, lookup_rdy=0; one resolve -> inflight_cnt=3 and lookup_rdy=1 next cycle.
REQ-032 SHALL cover: resolve_vld with empty FIFO -> resolve_err=1 for one cycle, table unchanged, mispredict=0.
REQ-033 SHALL cover: 2 in flight, flush with simultaneous lookup_vld and resolve_vld -> inflight_cnt=0 next cycle, no counter change, no mispredict.
REQ-034 SHALL cover: rst asserted at INIT index 7 -> sweep restarts at 0, init_busy lasts 16 further cycles.
